// File: rtl/note_pkg.sv
// Shared types and helpers for the note duration tracker.
package note_pkg;

  localparam int NUM_VOICES = 5;
  localparam int CLK_HZ     = 100_000_000;

  // Downstream positioning stage reads pitch class first, octave second.
  typedef struct packed {
    logic [3:0] pc;
    logic [3:0] oct;
  } note_t;

  // Pitch class 15 marks an empty slot for the positioning stage.
  localparam note_t NOTE_NULL = 8'hFF;

  typedef enum logic {
    SLOT_FREE = 1'b0,
    SLOT_HELD = 1'b1
  } slot_state_e;

  // MIDI key -> {key mod 12, key / 12}; both results fit in 4 bits for keys 0-127.
  function automatic note_t key_to_note(input logic [6:0] key);
    note_t n;
    n.pc  = 4'(key % 7'd12);
    n.oct = 4'(key / 7'd12);
    return n;
  endfunction

  // One-hot of the lowest set bit (all zeros when none set).
  function automatic logic [NUM_VOICES-1:0] lowest_set(input logic [NUM_VOICES-1:0] v);
    logic [NUM_VOICES-1:0] r;
    r = {NUM_VOICES{1'b0}};
    for (int i = NUM_VOICES - 1; i >= 0; i--) begin
      if (v[i]) begin
        r    = {NUM_VOICES{1'b0}};
        r[i] = 1'b1;
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/note_voice_slot.sv
// One voice slot: tracks a single held key, times it, and publishes it on release.
module note_voice_slot
  import note_pkg::*;
#(
  parameter int unsigned DUR_W      = 32,
  parameter logic [31:0] MIN_CYCLES = 32'd500_000
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             on_i,
  input  logic             off_i,
  input  logic             alloc_i,
  input  logic [6:0]       key_i,
  input  note_t            note_i,
  output logic             held_o,
  output logic             match_o,
  output logic             rel_o,
  output note_t            note_o,
  output logic [DUR_W-1:0] dur_o
);

  localparam logic [DUR_W-1:0] CNT_MAX = {DUR_W{1'b1}};

  slot_state_e      state_q, state_d;
  logic [6:0]       key_q, key_d;
  logic [DUR_W-1:0] cnt_q, cnt_d;
  note_t            note_q, note_d;
  logic [DUR_W-1:0] dur_q, dur_d;
  logic             rel_q, rel_d;
  logic [DUR_W-1:0] cnt_inc_s;
  logic             match_s;
  logic             long_enough_s;

  // The saturating increment doubles as the release duration (counter + 1).
  assign cnt_inc_s     = (cnt_q == CNT_MAX) ? CNT_MAX : cnt_q + DUR_W'(1);
  assign match_s       = (state_q == SLOT_HELD) && (key_q == key_i);
  assign long_enough_s = 64'(cnt_inc_s) >= 64'(MIN_CYCLES);

  // Next-state: allocate, count, retrigger, or release with glitch filtering.
  always_comb begin
    state_d = state_q;
    key_d   = key_q;
    cnt_d   = cnt_q;
    note_d  = note_q;
    dur_d   = dur_q;
    rel_d   = 1'b0;
    case (state_q)
      SLOT_FREE: begin
        if (alloc_i) begin
          state_d = SLOT_HELD;
          key_d   = key_i;
          cnt_d   = {DUR_W{1'b0}};
        end else begin
          state_d = SLOT_FREE;
        end
      end
      SLOT_HELD: begin
        if (on_i && match_s) begin
          cnt_d = {DUR_W{1'b0}};
        end else if (off_i && match_s) begin
          state_d = SLOT_FREE;
          if (long_enough_s) begin
            note_d = note_i;
            dur_d  = cnt_inc_s;
            rel_d  = 1'b1;
          end else begin
            rel_d = 1'b0;
          end
        end else begin
          cnt_d = cnt_inc_s;
        end
      end
      default: begin
        state_d = SLOT_FREE;
      end
    endcase
  end

  // Slot state and published outputs, cleared by synchronous reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= SLOT_FREE;
      key_q   <= 7'd0;
      cnt_q   <= {DUR_W{1'b0}};
      note_q  <= NOTE_NULL;
      dur_q   <= {DUR_W{1'b0}};
      rel_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      key_q   <= key_d;
      cnt_q   <= cnt_d;
      note_q  <= note_d;
      dur_q   <= dur_d;
      rel_q   <= rel_d;
    end
  end

  assign held_o  = (state_q == SLOT_HELD);
  assign match_o = match_s;
  assign rel_o   = rel_q;
  assign note_o  = note_q;
  assign dur_o   = dur_q;

endmodule

// File: rtl/note_duration_tracker.sv
// Allocates MIDI keys to voice slots and publishes released notes with hold times.
module note_duration_tracker
  import note_pkg::*;
#(
  parameter int unsigned DUR_W      = 32,
  parameter logic [31:0] MIN_CYCLES = 32'd500_000
) (
  input  logic                             clk_in,
  input  logic                             rst_in,
  input  logic                             midi_valid_in,
  input  logic                             midi_on_in,
  input  logic [6:0]                       midi_key_in,
  input  logic [6:0]                       midi_vel_in,
  output logic [NUM_VOICES-1:0][7:0]       notes_out,
  output logic [NUM_VOICES-1:0][DUR_W-1:0] durations_out,
  output logic [NUM_VOICES-1:0]            release_valid_out,
  output logic [NUM_VOICES-1:0]            active_mask_out,
  output logic                             overflow_out
);

  logic                  note_on_s;
  logic                  note_off_s;
  note_t                 note_s;
  logic [NUM_VOICES-1:0] held_s;
  logic [NUM_VOICES-1:0] match_s;
  logic [NUM_VOICES-1:0] alloc_s;
  logic                  any_match_s;
  logic                  ovf_d, ovf_q;

  // A note-on with zero velocity is the running-status form of note-off.
  assign note_on_s   = midi_valid_in & midi_on_in & (midi_vel_in != 7'd0);
  assign note_off_s  = midi_valid_in & (~midi_on_in | (midi_vel_in == 7'd0));
  assign note_s      = key_to_note(midi_key_in);
  assign any_match_s = |match_s;

  // New keys take the lowest free slot; a held key retriggers in place instead.
  always_comb begin
    alloc_s = {NUM_VOICES{1'b0}};
    ovf_d   = 1'b0;
    if (note_on_s && !any_match_s) begin
      alloc_s = lowest_set(~held_s);
      ovf_d   = (held_s == {NUM_VOICES{1'b1}});
    end else begin
      alloc_s = {NUM_VOICES{1'b0}};
      ovf_d   = 1'b0;
    end
  end

  // Overflow pulse follows the dropped note-on by one cycle.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      ovf_q <= 1'b0;
    end else begin
      ovf_q <= ovf_d;
    end
  end

  for (genvar g = 0; g < NUM_VOICES; g++) begin : g_slot
    note_voice_slot #(
      .DUR_W      (DUR_W),
      .MIN_CYCLES (MIN_CYCLES)
    ) u_slot (
      .clk_i   (clk_in),
      .rst_i   (rst_in),
      .on_i    (note_on_s),
      .off_i   (note_off_s),
      .alloc_i (alloc_s[g]),
      .key_i   (midi_key_in),
      .note_i  (note_s),
      .held_o  (held_s[g]),
      .match_o (match_s[g]),
      .rel_o   (release_valid_out[g]),
      .note_o  (notes_out[g]),
      .dur_o   (durations_out[g])
    );
  end

  assign active_mask_out = held_s;
  assign overflow_out    = ovf_q;

endmodule

// File: tb/tb_note_duration_tracker.sv
// Self-checking bench: timestamp-based model of voice allocation and hold durations.
module tb_note_duration_tracker;

  localparam int     NV   = 5;
  localparam int     DW   = 12;
  localparam int     MINC = 500;
  localparam longint SAT  = (64'd1 << DW) - 64'd1;

  logic                    clk_in = 1'b0;
  logic                    rst_in = 1'b1;
  logic                    midi_valid_in = 1'b0;
  logic                    midi_on_in = 1'b0;
  logic [6:0]              midi_key_in = 7'd0;
  logic [6:0]              midi_vel_in = 7'd0;
  logic [NV-1:0][7:0]      notes_out;
  logic [NV-1:0][DW-1:0]   durations_out;
  logic [NV-1:0]           release_valid_out;
  logic [NV-1:0]           active_mask_out;
  logic                    overflow_out;

  note_duration_tracker #(
    .DUR_W      (DW),
    .MIN_CYCLES (32'(MINC))
  ) dut (
    .clk_in            (clk_in),
    .rst_in            (rst_in),
    .midi_valid_in     (midi_valid_in),
    .midi_on_in        (midi_on_in),
    .midi_key_in       (midi_key_in),
    .midi_vel_in       (midi_vel_in),
    .notes_out         (notes_out),
    .durations_out     (durations_out),
    .release_valid_out (release_valid_out),
    .active_mask_out   (active_mask_out),
    .overflow_out      (overflow_out)
  );

  always #5 clk_in = ~clk_in;

  // Edge counter used as the model's time base.
  int cyc = 0;
  always @(posedge clk_in) cyc <= cyc + 1;

  // Model state: which key each slot holds (-1 = free) and the edge it was (re)started.
  int                    slot_key [NV];
  int                    slot_t0  [NV];
  int                    rel_at   [NV];
  int                    ovf_at;
  logic [NV-1:0][7:0]    exp_notes;
  logic [NV-1:0][DW-1:0] exp_durs;
  bit                    chk_en = 1'b0;
  logic [NV-1:0]         cmp_mask, cmp_rel;

  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Every-cycle comparison of all outputs against the model.
  always @(negedge clk_in) begin
    if (chk_en) begin
      for (int i = 0; i < NV; i++) begin
        cmp_mask[i] = (slot_key[i] >= 0);
        cmp_rel[i]  = (rel_at[i] == cyc);
      end
      check("active_mask", 64'(active_mask_out), 64'(cmp_mask));
      check("release_valid", 64'(release_valid_out), 64'(cmp_rel));
      check("overflow", 64'(overflow_out), 64'(ovf_at == cyc));
      check("notes", 64'(notes_out), 64'(exp_notes));
      check("durations", 64'(durations_out), 64'(exp_durs));
    end
  end

  task automatic do_reset(input int n);
    @(negedge clk_in);
    rst_in        = 1'b1;
    midi_valid_in = 1'b0;
    @(posedge clk_in);
    #1;
    for (int i = 0; i < NV; i++) begin
      slot_key[i]  = -1;
      slot_t0[i]   = 0;
      rel_at[i]    = -1;
      exp_notes[i] = 8'hFF;
      exp_durs[i]  = '0;
    end
    ovf_at = -1;
    chk_en = 1'b1;
    repeat (n - 1) @(posedge clk_in);
    @(negedge clk_in);
    rst_in = 1'b0;
  endtask

  // Drive one MIDI event for one cycle and advance the model at its accepting edge.
  task automatic send(input bit on, input int key, input int vel);
    int     hit, freei;
    longint d;
    @(negedge clk_in);
    midi_valid_in = 1'b1;
    midi_on_in    = on;
    midi_key_in   = 7'(key);
    midi_vel_in   = 7'(vel);
    @(posedge clk_in);
    #1;
    midi_valid_in = 1'b0;
    hit = -1;
    for (int i = 0; i < NV; i++) if (slot_key[i] == key) hit = i;
    if (on && vel != 0) begin
      if (hit >= 0) begin
        slot_t0[hit] = cyc;
      end else begin
        freei = -1;
        for (int i = NV - 1; i >= 0; i--) if (slot_key[i] < 0) freei = i;
        if (freei >= 0) begin
          slot_key[freei] = key;
          slot_t0[freei]  = cyc;
        end else begin
          ovf_at = cyc;
        end
      end
    end else if (hit >= 0) begin
      d = longint'(cyc - slot_t0[hit]);
      if (d > SAT) d = SAT;
      slot_key[hit] = -1;
      if (d >= MINC) begin
        exp_notes[hit] = {4'(key % 12), 4'(key / 12)};
        exp_durs[hit]  = DW'(d);
        rel_at[hit]    = cyc;
      end
    end
  endtask

  // Place the next event d edges after the previous one.
  task automatic gap(input int d);
    repeat (d - 1) @(posedge clk_in);
  endtask

  initial begin
    do_reset(3);
    @(negedge clk_in);
    check("lit_reset_notes", 64'(notes_out), 64'({NV{8'hFF}}));
    check("lit_reset_mask", 64'(active_mask_out), 64'd0);

    // Glitch: short hold ended by velocity-0 note-on is discarded.
    send(1'b1, 69, 64);
    gap(100);
    send(1'b1, 69, 0);
    @(negedge clk_in);
    check("lit_glitch_rel", 64'(release_valid_out), 64'd0);
    check("lit_glitch_note0", 64'(notes_out[0]), 64'h0FF);
    check("lit_glitch_mask", 64'(active_mask_out), 64'd0);

    // Long hold ended by velocity-0 note-on is published.
    send(1'b1, 69, 64);
    gap(1000);
    send(1'b1, 69, 0);
    @(negedge clk_in);
    check("lit_vel0_note0", 64'(notes_out[0]), 64'h095);
    check("lit_vel0_dur0", 64'(durations_out[0]), 64'd1000);

    // Basic hold with an explicit note-off.
    send(1'b1, 60, 64);
    gap(600);
    send(1'b0, 60, 64);
    @(negedge clk_in);
    check("lit_basic_rel", 64'(release_valid_out), 64'b00001);
    check("lit_basic_note0", 64'(notes_out[0]), 64'h005);
    check("lit_basic_dur0", 64'(durations_out[0]), 64'd600);

    // Unmatched note-off changes nothing.
    send(1'b0, 50, 64);
    gap(5);

    // Chord fills all slots, sixth key overflows.
    send(1'b1, 60, 100);
    send(1'b1, 64, 100);
    send(1'b1, 67, 100);
    send(1'b1, 71, 100);
    send(1'b1, 74, 100);
    send(1'b1, 77, 100);
    @(negedge clk_in);
    check("lit_chord_mask", 64'(active_mask_out), 64'b11111);
    check("lit_chord_ovf", 64'(overflow_out), 64'd1);
    gap(600);
    send(1'b0, 67, 0);
    @(negedge clk_in);
    check("lit_chord_rel", 64'(release_valid_out), 64'b00100);
    check("lit_chord_note2", 64'(notes_out[2]), 64'h075);
    // Freed slot 2 is reused by the next new key.
    send(1'b1, 80, 90);
    gap(3);
    send(1'b0, 60, 0);
    send(1'b0, 64, 0);
    send(1'b0, 71, 0);
    send(1'b0, 74, 0);
    send(1'b0, 77, 0);
    gap(520);
    send(1'b0, 80, 0);
    gap(3);

    // Retrigger restarts the count without a release.
    send(1'b1, 62, 64);
    gap(700);
    send(1'b1, 62, 80);
    gap(800);
    send(1'b0, 62, 64);
    @(negedge clk_in);
    check("lit_retrig_rel", 64'(release_valid_out), 64'b00001);
    check("lit_retrig_dur0", 64'(durations_out[0]), 64'd800);

    // Counter saturates at all-ones instead of wrapping.
    send(1'b1, 0, 64);
    gap(5000);
    send(1'b0, 0, 64);
    @(negedge clk_in);
    check("lit_sat_dur0", 64'(durations_out[0]), 64'hFFF);
    check("lit_sat_note0", 64'(notes_out[0]), 64'h000);

    // Reset with two notes held discards them silently.
    send(1'b1, 40, 64);
    send(1'b1, 41, 64);
    gap(10);
    do_reset(3);
    @(negedge clk_in);
    check("lit_rst_mask", 64'(active_mask_out), 64'd0);
    check("lit_rst_rel", 64'(release_valid_out), 64'd0);
    check("lit_rst_notes", 64'(notes_out), 64'({NV{8'hFF}}));
    check("lit_rst_durs", 64'(durations_out), 64'd0);
    send(1'b0, 40, 64);
    gap(5);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/note_duration_tracker.md
Name: note_duration_tracker

Overview:
- Sits directly upstream of the staff note-positioning stage and produces its notes_out/durations_out arrays.
- Consumes decoded MIDI note-on/note-off events from the MIDI receive path and allocates each sounding key to one of five voice slots.
- Counts the 100 MHz cycles each key is held.
- On release, publishes the key as packed note {pitch class, octave} plus its held duration in cycles.

Parameters:
- NUM_VOICES, 5, number of simultaneous voice slots; fixed to match downstream array width.
- MIN_CYCLES, 32'd500_000, releases shorter than this (5 ms) are treated as glitches and discarded.
- DUR_W, 32, duration counter width.

Ports:
- clk_in  input  1  system clock, 100 MHz.
- rst_in  input  1  synchronous, active-high reset.
- midi_valid_in  input  1  one-cycle strobe, event fields valid.
- midi_on_in  input  1  1 = note-on, 0 = note-off.
- midi_key_in  input  7  MIDI key number 0-127.
- midi_vel_in  input  7  velocity; note-on with velocity 0 is a note-off.
- notes_out  output  [4:0] x 8  per slot {pitch_class[7:4], octave[3:0]}.
- durations_out  output  [4:0] x 32  per slot, cycles the last released note was held.
- release_valid_out  output  5  one-cycle pulse per slot when its notes_out/durations_out update.
- active_mask_out  output  5  slot currently holding a sounding key.
- overflow_out  output  1  one-cycle pulse when a note-on was dropped because all slots were busy.

Behaviour:
- Reset:
  - All slots free; counters 0.
  - notes_out = 8'hFF per slot (pitch class 15, downstream default); durations_out = 0.
  - release_valid_out, active_mask_out and overflow_out = 0.
  - Reset mid-note discards held notes with no release pulse.
- Key conversion: pitch_class = key mod 12 (0-11), octave = key / 12 (0-10), computed combinationally from midi_key_in.
- Effective event:
  - note-off = midi_valid_in & (~midi_on_in | midi_vel_in == 0).
  - note-on = midi_valid_in & midi_on_in & midi_vel_in != 0.
- Per slot, two states, FREE and HELD:
  - FREE -> HELD: on a note-on when this is the lowest-index free slot and no slot holds the same key. Store key; counter <= 0.
  - HELD: counter increments every cycle and saturates at 2^32-1 (no wrap).
  - HELD -> FREE: on a note-off whose key matches the stored key. dur = counter + 1, saturating. dur equals the cycle count between note-on acceptance and note-off acceptance.
  - On HELD -> FREE with dur >= MIN_CYCLES: at the next edge, notes_out[i] <= packed note, durations_out[i] <= dur, release_valid_out[i] pulses for one cycle.
  - On HELD -> FREE with dur < MIN_CYCLES: slot freed silently; outputs unchanged, no pulse.
- Retrigger: a note-on for a key already HELD in slot i restarts that slot's counter at 0. No release is emitted and no new slot is allocated.
- Full: a note-on with no free slot and no matching key is dropped; overflow_out pulses the next cycle.
- Unmatched note-off (key not held): ignored, no output change.
- At most one event per cycle, so allocation and release never coincide. A slot freed in cycle T is allocatable from cycle T+1.
- Latency: active_mask_out and release_valid_out are registered, one cycle after the accepting edge.
- notes_out and durations_out hold their last values until that slot's next qualifying release.

Decomposition:
- Package note_pkg:
  - NUM_VOICES.
  - Packed note typedef {logic [3:0] pc; logic [3:0] oct}.
  - NOTE_NULL = 8'hFF.
  - CLK_HZ = 100_000_000.
- Sub-module note_voice_slot: one FREE/HELD FSM with saturating counter, match compare and release logic; instantiated NUM_VOICES times.
- Top level: key conversion, lowest-free priority encoder, match vector, overflow.

Test Plan:
- Basic hold: note-on key 60 vel 64 at cycle 10, note-off at cycle 600_010. Expect release_valid_out = 5'b00001 at cycle 600_011, notes_out[0] = 8'h05 (pc 0, octave 5), durations_out[0] = 600_000.
- Velocity-0 off and glitch filter: note-on key 69 then note-on key 69 vel 0 after 1_000 cycles. Expect slot freed, no pulse, notes_out[0] still 8'hFF. Repeat with a 1_000_000-cycle hold: expect pulse, notes_out[0] = 8'h95, durations_out[0] = 1_000_000.
- Chord and overflow: note-on keys 60, 64, 67, 71, 74, 77 in consecutive cycles. Expect active_mask_out = 5'b11111 and an overflow_out pulse after key 77. Releasing key 67 pulses slot 2 only.
- Retrigger: note-on key 62, note-on key 62 again 700_000 cycles later, note-off 800_000 cycles after that. Expect one release on slot 0 with durations_out[0] = 800_000.
- Saturation and reset: force counter near 2^32-2, hold past limit. Expect durations_out = 32'hFFFF_FFFF. Assert rst_in while two notes are held: expect all outputs at reset values and no release pulse.
